// File: rtl/array_9_arb.sv
// Two-port (A/B) round-robin arbiter in front of a single-port synchronous array, with power-up clear.
// Latency: grant is combinational; read data is returned via resp_valid two cycles after the grant.
// Backpressure: a read is only granted once the port's response slot is free or draining this cycle; writes are never blocked in RUN.
module array_9_arb #(
  parameter int DATA_W = 1176,
  parameter int ADDR_W = 3,
  parameter int MASK_W = 4
) (
  input  logic              RW0_clk,
  input  logic              reset,
  input  logic              a_req_valid,
  output logic              a_req_ready,
  input  logic              a_req_write,
  input  logic [ADDR_W-1:0] a_req_addr,
  input  logic [MASK_W-1:0] a_req_wmask,
  input  logic [DATA_W-1:0] a_req_wdata,
  output logic              a_resp_valid,
  input  logic              a_resp_ready,
  output logic [DATA_W-1:0] a_resp_rdata,
  input  logic              b_req_valid,
  output logic              b_req_ready,
  input  logic              b_req_write,
  input  logic [ADDR_W-1:0] b_req_addr,
  input  logic [MASK_W-1:0] b_req_wmask,
  input  logic [DATA_W-1:0] b_req_wdata,
  output logic              b_resp_valid,
  input  logic              b_resp_ready,
  output logic [DATA_W-1:0] b_resp_rdata,
  output logic              mem_en,
  output logic              mem_wmode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [MASK_W-1:0] mem_wmask,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              init_done
);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
  logic              rr_ptr_q;   // 0 = A has priority, 1 = B has priority
  logic              a_pend_q, b_pend_q;
  logic              run;
  logic              a_elig, b_elig;
  logic              a_gnt, b_gnt;

  assign run       = (state_q == ST_RUN);
  assign init_done = run;

  // A read may only go out when its response register will be free by the time data returns
  assign a_elig = run && a_req_valid &&
                  (a_req_write || (!a_pend_q && (!a_resp_valid || a_resp_ready)));
  assign b_elig = run && b_req_valid &&
                  (b_req_write || (!b_pend_q && (!b_resp_valid || b_resp_ready)));

  assign a_gnt = a_elig && (!b_elig || !rr_ptr_q);
  assign b_gnt = b_elig && (!a_elig ||  rr_ptr_q);

  // State and clear-counter registers
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_INIT;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Next state plus array command mux: clear sweep in INIT, granted port's payload in RUN
  always_comb begin
    state_d     = state_q;
    clr_cnt_d   = clr_cnt_q;
    mem_en      = 1'b0;
    mem_wmode   = 1'b0;
    mem_addr    = '0;
    mem_wmask   = '0;
    mem_wdata   = '0;
    a_req_ready = 1'b0;
    b_req_ready = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_en    = 1'b1;
        mem_wmode = 1'b1;
        mem_addr  = clr_cnt_q;
        mem_wmask = '1;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == LAST_ADDR) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        a_req_ready = a_gnt;
        b_req_ready = b_gnt;
        if (a_gnt) begin
          mem_en    = 1'b1;
          mem_wmode = a_req_write;
          mem_addr  = a_req_addr;
          mem_wmask = a_req_wmask;
          mem_wdata = a_req_wdata;
        end else if (b_gnt) begin
          mem_en    = 1'b1;
          mem_wmode = b_req_write;
          mem_addr  = b_req_addr;
          mem_wmask = b_req_wmask;
          mem_wdata = b_req_wdata;
        end
      end
    endcase
  end

  // Round-robin pointer hands priority to the loser after every grant, holds otherwise
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q <= 1'b0;
    end else if (a_gnt) begin
      rr_ptr_q <= 1'b1;
    end else if (b_gnt) begin
      rr_ptr_q <= 1'b0;
    end
  end

  // Port A read tracking: pending for one cycle, then capture array data into the response register
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      a_pend_q     <= 1'b0;
      a_resp_valid <= 1'b0;
      a_resp_rdata <= '0;
    end else begin
      a_pend_q <= a_gnt && !a_req_write;
      if (a_pend_q) begin
        a_resp_valid <= 1'b1;
        a_resp_rdata <= mem_rdata;
      end else if (a_resp_valid && a_resp_ready) begin
        a_resp_valid <= 1'b0;
      end
    end
  end

  // Port B read tracking, identical to port A
  always_ff @(posedge RW0_clk or posedge reset) begin
    if (reset) begin
      b_pend_q     <= 1'b0;
      b_resp_valid <= 1'b0;
      b_resp_rdata <= '0;
    end else begin
      b_pend_q <= b_gnt && !b_req_write;
      if (b_pend_q) begin
        b_resp_valid <= 1'b1;
        b_resp_rdata <= mem_rdata;
      end else if (b_resp_valid && b_resp_ready) begin
        b_resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_array_9_arb.sv
// Bench for array_9_arb: directed scenarios followed by randomized traffic, checked every cycle
// against a transaction-level model (shadow array, per-port response slot with due cycle, RR pointer).
// The synchronous array itself is modelled behaviourally and driven by the DUT's mem_* command.
module tb_array_9_arb;
  localparam int DATA_W = 1176;
  localparam int ADDR_W = 3;
  localparam int MASK_W = 4;
  localparam int LANE_W = DATA_W / MASK_W;
  localparam int DEPTH  = 2 ** ADDR_W;

  typedef logic [DATA_W-1:0] word_t;

  logic              RW0_clk;
  logic              reset;
  logic              a_req_valid, a_req_ready, a_req_write, a_resp_valid, a_resp_ready;
  logic [ADDR_W-1:0] a_req_addr;
  logic [MASK_W-1:0] a_req_wmask;
  word_t             a_req_wdata, a_resp_rdata;
  logic              b_req_valid, b_req_ready, b_req_write, b_resp_valid, b_resp_ready;
  logic [ADDR_W-1:0] b_req_addr;
  logic [MASK_W-1:0] b_req_wmask;
  word_t             b_req_wdata, b_resp_rdata;
  logic              mem_en, mem_wmode, init_done;
  logic [ADDR_W-1:0] mem_addr;
  logic [MASK_W-1:0] mem_wmask;
  word_t             mem_wdata, mem_rdata;

  int n_err;
  int n_checks;

  array_9_arb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .MASK_W(MASK_W)) dut (
    .RW0_clk(RW0_clk), .reset(reset),
    .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_write(a_req_write),
    .a_req_addr(a_req_addr), .a_req_wmask(a_req_wmask), .a_req_wdata(a_req_wdata),
    .a_resp_valid(a_resp_valid), .a_resp_ready(a_resp_ready), .a_resp_rdata(a_resp_rdata),
    .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_write(b_req_write),
    .b_req_addr(b_req_addr), .b_req_wmask(b_req_wmask), .b_req_wdata(b_req_wdata),
    .b_resp_valid(b_resp_valid), .b_resp_ready(b_resp_ready), .b_resp_rdata(b_resp_rdata),
    .mem_en(mem_en), .mem_wmode(mem_wmode), .mem_addr(mem_addr), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .init_done(init_done)
  );

  initial RW0_clk = 1'b0;
  always #5 RW0_clk = ~RW0_clk;

  function automatic word_t rand_word();
    word_t       w;
    logic [31:0] r;
    w = '0;
    r = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (i % 32 == 0) r = $urandom;
      w[i] = r[i % 32];
    end
    return w;
  endfunction

  function automatic word_t apply_mask(word_t old, word_t nw, logic [MASK_W-1:0] m);
    word_t res;
    res = old;
    for (int l = 0; l < MASK_W; l++) begin
      if (m[l]) res[l*LANE_W +: LANE_W] = nw[l*LANE_W +: LANE_W];
    end
    return res;
  endfunction

  // Behavioural synchronous array: seeded with junk, read data appears the cycle after a read command
  word_t arr [DEPTH];
  logic  mem_seeded = 1'b0;
  always @(posedge RW0_clk) begin
    if (!mem_seeded) begin
      for (int i = 0; i < DEPTH; i++) arr[i] <= rand_word();
      mem_seeded <= 1'b1;
    end else if (mem_en) begin
      if (mem_wmode) arr[mem_addr] <= apply_mask(arr[mem_addr], mem_wdata, mem_wmask);
      else           mem_rdata     <= arr[mem_addr];
    end
  end

  // Reference model state
  word_t ref_mem [DEPTH];
  int    init_cnt;
  bit    m_ptr;
  bit    have_rsp [2];
  word_t rsp_data [2];
  int    rsp_cycle [2];
  int    cyc;
  int    gcnt_a, gcnt_b;

  task automatic chk(input string tag, input word_t obs, input word_t exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h (low 128 bits)", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // One clock cycle: check outputs at negedge against the model, then advance the model at posedge
  task automatic tick();
    bit                valid [2];
    bit                wr [2];
    bit                rr [2];
    logic [ADDR_W-1:0] ad [2];
    logic [MASK_W-1:0] mk [2];
    word_t             wd [2];
    bit                vis [2];
    bit                elig [2];
    bit                in_init;
    int                g;
    @(negedge RW0_clk);
    valid[0] = a_req_valid; wr[0] = a_req_write; rr[0] = a_resp_ready;
    ad[0] = a_req_addr; mk[0] = a_req_wmask; wd[0] = a_req_wdata;
    valid[1] = b_req_valid; wr[1] = b_req_write; rr[1] = b_resp_ready;
    ad[1] = b_req_addr; mk[1] = b_req_wmask; wd[1] = b_req_wdata;
    if (reset) begin
      init_cnt = 0;
      m_ptr = 1'b0;
      for (int p = 0; p < 2; p++) have_rsp[p] = 1'b0;
    end
    in_init = (init_cnt < DEPTH);
    for (int p = 0; p < 2; p++) begin
      vis[p]  = have_rsp[p] && (cyc >= rsp_cycle[p]);
      elig[p] = !in_init && valid[p] && (wr[p] || !have_rsp[p] || (vis[p] && rr[p]));
    end
    g = -1;
    if (elig[0] && elig[1]) g = int'(m_ptr);
    else if (elig[0])       g = 0;
    else if (elig[1])       g = 1;
    if (a_req_ready) gcnt_a++;
    if (b_req_ready) gcnt_b++;

    chk("a_req_ready", word_t'(a_req_ready), word_t'(g == 0));
    chk("b_req_ready", word_t'(b_req_ready), word_t'(g == 1));
    chk("init_done", word_t'(init_done), word_t'(!in_init));
    if (in_init) begin
      chk("init_en",    word_t'(mem_en),    word_t'(1'b1));
      chk("init_wmode", word_t'(mem_wmode), word_t'(1'b1));
      chk("init_addr",  word_t'(mem_addr),  word_t'(init_cnt));
      chk("init_wmask", word_t'(mem_wmask), word_t'(4'hF));
      chk("init_wdata", mem_wdata, '0);
    end else if (g >= 0) begin
      chk("mem_en",    word_t'(mem_en),    word_t'(1'b1));
      chk("mem_wmode", word_t'(mem_wmode), word_t'(wr[g]));
      chk("mem_addr",  word_t'(mem_addr),  word_t'(ad[g]));
      chk("mem_wmask", word_t'(mem_wmask), word_t'(mk[g]));
      chk("mem_wdata", mem_wdata, wd[g]);
    end else begin
      chk("mem_en_idle", word_t'(mem_en), word_t'(1'b0));
    end
    chk("a_resp_valid", word_t'(a_resp_valid), word_t'(vis[0]));
    chk("b_resp_valid", word_t'(b_resp_valid), word_t'(vis[1]));
    if (vis[0]) chk("a_resp_rdata", a_resp_rdata, rsp_data[0]);
    if (vis[1]) chk("b_resp_rdata", b_resp_rdata, rsp_data[1]);
    if (reset) begin
      chk("rst_a_rdata", a_resp_rdata, '0);
      chk("rst_b_rdata", b_resp_rdata, '0);
    end

    @(posedge RW0_clk);
    if (!reset) begin
      if (in_init) begin
        init_cnt++;
        if (init_cnt == DEPTH) for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
      end
      for (int p = 0; p < 2; p++) if (vis[p] && rr[p]) have_rsp[p] = 1'b0;
      if (g >= 0) begin
        if (wr[g]) begin
          ref_mem[ad[g]] = apply_mask(ref_mem[ad[g]], wd[g], mk[g]);
        end else begin
          have_rsp[g]  = 1'b1;
          rsp_data[g]  = ref_mem[ad[g]];
          rsp_cycle[g] = cyc + 2;
        end
        m_ptr = (g == 0);
      end
    end
    cyc++;
    #1;
  endtask

  word_t p_word, x_word, y_word, exp_a1;

  initial begin
    n_err = 0; n_checks = 0; cyc = 0; init_cnt = 0; m_ptr = 1'b0;
    gcnt_a = 0; gcnt_b = 0;
    for (int p = 0; p < 2; p++) begin have_rsp[p] = 1'b0; rsp_data[p] = '0; rsp_cycle[p] = 0; end
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    a_req_valid = 0; a_req_write = 0; a_req_addr = '0; a_req_wmask = '0; a_req_wdata = '0; a_resp_ready = 0;
    b_req_valid = 0; b_req_write = 0; b_req_addr = '0; b_req_wmask = '0; b_req_wdata = '0; b_resp_ready = 0;
    reset = 1'b0;
    #1;
    reset = 1'b1;

    // Reset state, then reset in the middle of the clear sweep
    repeat (2) tick();
    reset = 1'b0;
    repeat (4) tick();
    #2;
    chk("init_at_addr4", word_t'(mem_addr), word_t'(4));
    reset = 1'b1;
    #1;
    chk("midinit_rst_init_done", word_t'(init_done), word_t'(1'b0));
    chk("midinit_rst_addr", word_t'(mem_addr), word_t'(0));
    repeat (2) tick();
    reset = 1'b0;

    // Full clear sweep restarting from address 0, init_done on the 9th cycle
    repeat (8) tick();
    #2;
    chk("init_done_9th", word_t'(init_done), word_t'(1'b1));

    // Read of a cleared location returns zero two cycles after the grant
    a_req_valid = 1; a_req_write = 0; a_req_addr = 3'd5; a_resp_ready = 1;
    tick();
    a_req_valid = 0;
    tick();
    #2;
    chk("clr_rd_valid", word_t'(a_resp_valid), word_t'(1'b1));
    chk("clr_rd_data", a_resp_rdata, '0);
    tick();

    // Masked write on A, read back on B
    p_word = rand_word();
    a_req_valid = 1; a_req_write = 1; a_req_addr = 3'd2; a_req_wmask = 4'b0101; a_req_wdata = p_word;
    tick();
    a_req_valid = 0;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 3'd2; b_resp_ready = 1;
    tick();
    b_req_valid = 0;
    tick();
    #2;
    chk("mask_rd_valid", word_t'(b_resp_valid), word_t'(1'b1));
    chk("mask_rd_lanes", b_resp_rdata, apply_mask('0, p_word, 4'b0101));
    tick();

    // Both ports stream reads: grants alternate, one read per port every two cycles
    gcnt_a = 0; gcnt_b = 0;
    a_req_valid = 1; a_req_write = 0; a_req_addr = 3'd1; a_resp_ready = 1;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 3'd2; b_resp_ready = 1;
    repeat (10) tick();
    chk("rr_grants_a", word_t'(gcnt_a), word_t'(5));
    chk("rr_grants_b", word_t'(gcnt_b), word_t'(5));
    a_req_valid = 0; b_req_valid = 0;
    repeat (3) tick();

    // Response backpressure on A holds the second read and keeps the data stable
    a_req_valid = 1; a_req_write = 1; a_req_addr = 3'd1; a_req_wmask = 4'hF; a_req_wdata = rand_word();
    tick();
    exp_a1 = ref_mem[1];
    a_req_write = 0; a_resp_ready = 0;
    tick();
    a_req_addr = 3'd6;
    repeat (5) tick();
    #2;
    chk("bp_second_held", word_t'(a_req_ready), word_t'(1'b0));
    chk("bp_data_stable", a_resp_rdata, exp_a1);
    a_resp_ready = 1;
    tick();
    a_req_valid = 0;
    repeat (3) tick();

    // Write-after-read to the same address: read sees old data, later read sees new
    x_word = rand_word();
    y_word = rand_word();
    a_req_valid = 1; a_req_write = 1; a_req_addr = 3'd3; a_req_wmask = 4'hF; a_req_wdata = x_word;
    tick();
    a_req_valid = 0;
    b_req_valid = 1; b_req_write = 0; b_req_addr = 3'd3; b_resp_ready = 1;
    tick();
    b_req_valid = 0;
    a_req_valid = 1; a_req_write = 1; a_req_addr = 3'd3; a_req_wmask = 4'hF; a_req_wdata = y_word;
    tick();
    a_req_valid = 0;
    #2;
    chk("war_old_data", b_resp_rdata, x_word);
    tick();
    b_req_valid = 1;
    tick();
    b_req_valid = 0;
    tick();
    #2;
    chk("war_new_data", b_resp_rdata, y_word);
    tick();

    // Reset while a read is pending discards the response
    b_req_valid = 1; b_req_write = 0; b_req_addr = 3'd3;
    tick();
    b_req_valid = 0;
    reset = 1'b1;
    #1;
    chk("pend_rst_resp_valid", word_t'(b_resp_valid), word_t'(1'b0));
    repeat (2) tick();
    reset = 1'b0;
    repeat (9) tick();

    // Randomized traffic with one mid-run reset pulse
    for (int c = 0; c < 600; c++) begin
      a_req_valid  = ($urandom_range(0, 3) != 0);
      a_req_write  = ($urandom_range(0, 2) == 0);
      a_req_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      a_req_wmask  = MASK_W'($urandom);
      a_req_wdata  = rand_word();
      a_resp_ready = ($urandom_range(0, 3) != 0);
      b_req_valid  = ($urandom_range(0, 3) != 0);
      b_req_write  = ($urandom_range(0, 2) == 0);
      b_req_addr   = ADDR_W'($urandom_range(0, DEPTH - 1));
      b_req_wmask  = MASK_W'($urandom);
      b_req_wdata  = rand_word();
      b_resp_ready = ($urandom_range(0, 3) != 0);
      reset        = (c == 300);
      tick();
    end
    reset = 1'b0;
    a_req_valid = 0; b_req_valid = 0; a_resp_ready = 1; b_resp_ready = 1;
    repeat (4) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/array_9_arb.md
ARRAY_9_ARB -- requirements
Module: array_9_arb

Interface
REQ-001 Parameter DATA_W, default 1176, SHALL set the array word width in bits.
REQ-002 Parameter ADDR_W, default 3, SHALL set the address width; depth = 2**ADDR_W (8).
REQ-003 Parameter MASK_W, default 4, SHALL set the write-mask lanes; lane width = DATA_W/MASK_W (294).
REQ-004 clock  in  1  sole clock, all state on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 a_req_valid / a_req_ready  in / out  1  port A request handshake.
REQ-007 a_req_write  in  1  1 = write, 0 = read.
REQ-008 a_req_addr / a_req_wmask / a_req_wdata  in  ADDR_W / MASK_W / DATA_W  port A request payload.
REQ-009 a_resp_valid / a_resp_ready  out / in  1  port A read-response handshake.
REQ-010 a_resp_rdata  out  DATA_W  port A read data, held while a_resp_valid is high.
REQ-011 b_* ports SHALL mirror REQ-006..010 for port B.
REQ-012 mem_en / mem_wmode  out  1  array enable and write mode.
REQ-013 mem_addr / mem_wmask / mem_wdata  out  ADDR_W / MASK_W / DATA_W  array command.
REQ-014 mem_rdata  in  DATA_W  array read data, valid the cycle after a read command.
REQ-015 init_done  out  1  high once the array clear has completed.

Function
REQ-016 States SHALL be INIT and RUN; reset SHALL enter INIT with the clear counter at 0.
REQ-017 INIT SHALL issue one write per cycle: mem_en=1, mem_wmode=1, mem_addr=counter, mem_wmask=all ones, mem_wdata=0; the counter increments each cycle.
REQ-018 After the write to the last address (7), the block SHALL enter RUN and assert init_done from the next cycle; init_done stays high until reset.
REQ-019 In INIT, a_req_ready and b_req_ready SHALL be 0.
REQ-020 In RUN, a write request SHALL always be eligible.
REQ-021 In RUN, a read request SHALL be eligible only when no read is pending for that port and (resp_valid=0 or resp_ready=1).
REQ-022 With one eligible port, that port SHALL be granted; with two, the round-robin pointer SHALL choose.
REQ-023 The round-robin pointer SHALL reset to A and, after each grant, move to the port not granted; it SHALL NOT change in cycles without a grant.
REQ-024 req_ready of the granted port SHALL be 1 in the grant cycle (combinational from req_valid) and 0 for the other port.
REQ-025 In a grant cycle, mem_en=1 and mem_wmode/addr/wmask/wdata SHALL be the granted port's payload; with no grant, mem_en=0.
REQ-026 A read granted in cycle T SHALL set that port's pending flag at the T edge, capture mem_rdata into resp_rdata at the T+1 edge, and assert resp_valid in T+2.
REQ-027 resp_valid SHALL clear on the edge where resp_valid and resp_ready are both 1, unless a capture occurs on that same edge, in which case it stays 1 with the new data.
REQ-028 A write granted in cycle T+1 to the address of a read granted in T SHALL NOT affect that read; the read returns pre-write data.
REQ-029 Writes SHALL produce no response.
REQ-030 Outputs at reset: all req_ready, resp_valid, init_done and the pending flags = 0; resp_rdata = 0; pointer = A.

Reset
REQ-031 Reset asserted at any time, including mid-INIT or with a read pending, SHALL immediately clear all state per REQ-030 and discard in-flight responses.
REQ-032 On reset release, INIT SHALL restart from address 0.

Verification
REQ-033 Reset release -> 8 cycles of mem_en=1, mem_wmode=1, addresses 0..7, wdata=0; init_done=1 on the 9th cycle; then a read of addr 5 returns 0.
REQ-034 A writes addr 2 with wmask=4'b0101 and pattern P -> B reads addr 2 -> lanes 0 and 2 = P, lanes 1 and 3 = 0; resp_valid 2 cycles after grant.
REQ-035 A and B hold req_valid continuously (reads, resp_ready=1) -> grants alternate A,B,A,B; each port gets one read per 2 cycles.
REQ-036 A read is issued with a_resp_ready=0 and a second A read is held -> the second read is not granted until a_resp_ready=1, and a_resp_rdata is held stable meanwhile.
REQ-037 B reads addr 3 in cycle T and A writes addr 3 in T+1 -> B receives the old data; a later read returns the new data.
REQ-038 Reset asserted at INIT address 4 -> init_done stays 0, and the clear restarts at address 0 after release.
